// File: rtl/cpwbuf_pkg.sv
// Shared types and constants for the halfword-to-SDRAM write buffer.
// Holds the burst FSM encoding and the flush pad value.
package cpwbuf_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam logic [15:0] PAD = 16'hFFFF;

endpackage

// File: rtl/cpwbuf_fifo.sv
// Register FIFO of packed 64-bit words, head visible with no latency.
// Contents are not reset; only pointers and occupancy are.
module cpwbuf_fifo #(
    parameter int AW = 4,
    parameter int W  = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [AW:0]  count,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int N = 1 << AW;

    logic [W-1:0]  mem [N];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(N));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rp];

    // Storage write; data registers carry no reset.
    always_ff @(posedge clock) begin
        if (do_push)
            mem[wp] <= din;
    end

    // Pointers wrap naturally; simultaneous push/pop keeps count.
    always_ff @(posedge clock) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wp <= wp + 1'b1;
            if (do_pop)
                rp <= rp + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpwbuf.sv
// Packs 16-bit halfwords into 64-bit words and drains them in bursts.
// Packer, flush control and burst FSM live here; storage is cpwbuf_fifo.
module cpwbuf
    import cpwbuf_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int BURST      = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr,
    input  logic [15:0] data,
    input  logic        flush,
    output logic        full,
    output logic        busy,
    output logic        overflow,
    output logic        req,
    input  logic        rd,
    output logic [63:0] q,
    output logic        last
);

    localparam logic [DEPTH_LOG2:0] BURST_C = (DEPTH_LOG2+1)'(BURST);

    state_t                state;
    state_t                state_nxt;
    logic [1:0]            idx;
    logic [47:0]           hold;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   bcnt;
    logic                  fifo_empty;
    logic                  accept;
    logic                  pad;
    logic                  push;
    logic                  pop;
    logic [63:0]           din;

    assign accept = wr && !full && !busy;
    assign pad    = busy && (idx != 2'd0) && !full;
    assign push   = (accept && idx == 2'd3) || pad;
    assign pop    = rd && (state == XFER);
    assign req    = (state == XFER);
    assign last   = req && (bcnt == (DEPTH_LOG2+1)'(1));

    cpwbuf_fifo #(
        .AW (DEPTH_LOG2),
        .W  (64)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .count (count),
        .full  (full),
        .empty (fifo_empty),
        .head  (q)
    );

    // Word to push: completed group, or partial group padded on flush.
    always_comb begin
        din = {data, hold};
        if (pad) begin
            case (idx)
                2'd1:    din = {PAD, PAD, PAD, hold[15:0]};
                2'd2:    din = {PAD, PAD, hold[31:0]};
                2'd3:    din = {PAD, hold[47:0]};
                default: din = {data, hold};
            endcase
        end
    end

    // Packer: collect the first three halfwords, fourth completes a word.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx <= 2'd0;
        end else if (accept) begin
            case (idx)
                2'd0:    hold[15:0]  <= data;
                2'd1:    hold[31:16] <= data;
                2'd2:    hold[47:32] <= data;
                default: hold        <= hold;
            endcase
            idx <= idx + 2'd1;
        end else if (pad) begin
            idx <= 2'd0;
        end
    end

    // Flush tracking and sticky drop flag; a flush with nothing held is a no-op.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr && !accept)
                overflow <= 1'b1;
            if (!busy) begin
                if (flush && (idx != 2'd0 || count != '0 ||
                              state != IDLE || accept))
                    busy <= 1'b1;
            end else if (idx == 2'd0 && fifo_empty && state == IDLE) begin
                busy <= 1'b0;
            end
        end
    end

    // Burst state register.
    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A flush waits for the padded word so the tail drains as one burst.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (count >= BURST_C ||
                    (busy && idx == 2'd0 && !fifo_empty))
                    state_nxt = XFER;
            end
            XFER: begin
                if (rd && last)
                    state_nxt = IDLE;
            end
        endcase
    end

    // Burst length latched on entry, counted down per pop.
    always_ff @(posedge clock) begin
        if (reset)
            bcnt <= '0;
        else if (state == IDLE && state_nxt == XFER)
            bcnt <= (count < BURST_C) ? count : BURST_C;
        else if (pop)
            bcnt <= bcnt - 1'b1;
    end

endmodule
